// File: rtl/spu_fetch_unit_if.sv
// Fetch-unit bus bundle: odd-pipe redirect, local-store line read port, decode/issue outputs.
// Latency: none, wires only.
// Backpressure: stall is driven by the slave side (decode/issue) and is honoured by the master (fetch unit).
interface spu_fetch_unit_if #(
  parameter int LS_ADDR_W = 15
);
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic                 stall;
  logic                 ls_rd_req;
  logic [LS_ADDR_W-1:0] ls_rd_addr;
  logic                 ls_rd_valid;
  logic [127:0]         ls_rd_data;
  logic [31:0]          instr0;
  logic [31:0]          instr1;
  logic [1:0]           instr_valid;
  logic [31:0]          PC_input;

  // Fetch unit side
  modport master (
    input  branch_taken, branch_target, stall, ls_rd_valid, ls_rd_data,
    output ls_rd_req, ls_rd_addr, instr0, instr1, instr_valid, PC_input
  );

  // Pipeline / local store side
  modport slave (
    output branch_taken, branch_target, stall, ls_rd_valid, ls_rd_data,
    input  ls_rd_req, ls_rd_addr, instr0, instr1, instr_valid, PC_input
  );
endinterface

// File: rtl/spu_fetch_unit.sv
// SPU instruction fetch: reads 128-bit local-store lines into a circular buffer, issues up to 2 instr/cycle.
// Latency: line written at edge N is on instr0 after edge N+1; request-to-first-issue >= 3 cycles.
// Backpressure: stall freezes the issue registers; fetch continues while >= 4 buffer slots are free.
// Optional: SPU_FETCH_PERF_CNT_EN adds saturating flush_cnt / starve_cnt outputs.
module spu_fetch_unit #(
  parameter int          IBUF_DEPTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          LS_ADDR_W  = 15
) (
  input logic              clock,
  input logic              reset,
  spu_fetch_unit_if.master bus
`ifdef SPU_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]      flush_cnt,
  output logic [15:0]      starve_cnt
`endif
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  // A new line may be requested only while this many entries or fewer are occupied.
  localparam logic [CW-1:0] FILL_LIMIT = CW'(IBUF_DEPTH - 4);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state;
  logic [31:2]   fpc;
  logic [31:0]   ipc;
  logic [31:0]   ibuf [IBUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic [2:0]    wr_n;
  logic [1:0]    rd_n;

  // Words written and read this cycle; a redirect cancels both.
  always_comb begin
    accept = (state == WAIT) && bus.ls_rd_valid && !bus.branch_taken;
    wr_n   = accept ? (3'd4 - {1'b0, fpc[3:2]}) : 3'd0;
    rd_n   = 2'd0;
    if (!bus.branch_taken && !bus.stall) begin
      if (count >= CW'(2))
        rd_n = 2'd2;
      else if (count == CW'(1))
        rd_n = 2'd1;
    end
  end

  // Buffer storage: write the words of the returned line from the fetch entry point up to word 3.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (accept && (k >= int'(fpc[3:2])))
        ibuf[wr_ptr + PW'(k) - PW'(fpc[3:2])] <= bus.ls_rd_data[32*k +: 32];
    end
  end

  // Fetch FSM, buffer pointers and issue registers; redirect overrides everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      fpc             <= RESET_PC[31:2];
      ipc             <= RESET_PC;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.ls_rd_req   <= 1'b0;
      bus.ls_rd_addr  <= '0;
      bus.instr0      <= '0;
      bus.instr1      <= '0;
      bus.instr_valid <= 2'b00;
      bus.PC_input    <= RESET_PC;
    end else if (bus.branch_taken) begin
      fpc             <= bus.branch_target[31:2];
      ipc             <= {bus.branch_target[31:2], 2'b00};
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.ls_rd_req   <= 1'b0;
      bus.instr_valid <= 2'b00;
      bus.PC_input    <= {bus.branch_target[31:2], 2'b00};
      // A still-outstanding line must be swallowed before refetching.
      case (state)
        WAIT, DISCARD: state <= bus.ls_rd_valid ? IDLE : DISCARD;
        default:       state <= IDLE;
      endcase
    end else begin
      bus.ls_rd_req <= 1'b0;
      case (state)
        IDLE: begin
          if (count <= FILL_LIMIT) begin
            bus.ls_rd_req  <= 1'b1;
            bus.ls_rd_addr <= {fpc[LS_ADDR_W-1:4], 4'b0000};
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (bus.ls_rd_valid) begin
            fpc   <= {fpc[31:4] + 28'd1, 2'b00};
            state <= IDLE;
          end
        end
        DISCARD: begin
          if (bus.ls_rd_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      wr_ptr <= wr_ptr + PW'(wr_n);
      count  <= count + CW'(wr_n) - CW'(rd_n);

      if (!bus.stall) begin
        rd_ptr          <= rd_ptr + PW'(rd_n);
        ipc             <= ipc + {28'd0, rd_n, 2'b00};
        bus.PC_input    <= ipc;
        bus.instr_valid <= {rd_n[1], |rd_n};
        if (rd_n != 2'd0)
          bus.instr0 <= ibuf[rd_ptr];
        if (rd_n == 2'd2)
          bus.instr1 <= ibuf[rd_ptr + PW'(1)];
      end
    end
  end

`ifdef SPU_FETCH_PERF_CNT_EN
  // Saturating counters of redirects and of issue slots lost to an empty buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (bus.branch_taken && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
      if (!bus.stall && (count == '0) && (starve_cnt != 16'hFFFF))
        starve_cnt <= starve_cnt + 16'd1;
    end
  end
`else
  // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_spu_fetch_unit.sv
module tb_spu_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spu_fetch_unit_if #(.LS_ADDR_W(15)) bus ();

`ifdef SPU_FETCH_PERF_CNT_EN
  logic [15:0] flush_cnt;
  logic [15:0] starve_cnt;
`endif

  spu_fetch_unit #(.IBUF_DEPTH(8), .RESET_PC(RESET_PC), .LS_ADDR_W(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef SPU_FETCH_PERF_CNT_EN
    ,
    .flush_cnt  (flush_cnt),
    .starve_cnt (starve_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Bench-side state: local-store responder and expected instruction stream
  logic        pending;
  int          cd;
  int          lat_max;
  logic [14:0] pend_addr;
  logic [14:0] next_req;
  logic [31:0] exp_pc;
  int          nreq;
  int          nbr;
  int          issued;
  logic [1:0]  prev_v;
  logic [31:0] prev_pc, prev_i0, prev_i1;

  typedef struct packed {
    logic        stall;
    logic        exp_req;
    logic [14:0] exp_addr;
    logic [1:0]  exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_i0;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: each word holds 0x1000_0000 + its word index in the local store
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + {19'd0, a[14:2]};
  endfunction

  function automatic logic [127:0] line_data(input logic [14:0] a);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = word_at({17'd0, a} + 32'(4 * k));
    return d;
  endfunction

  // One clock: apply inputs, then check outputs and run the local-store responder
  task automatic tick();
    logic        br, st, was_pending;
    logic [31:0] tgt;
    br  = bus.branch_taken;
    tgt = bus.branch_target;
    st  = bus.stall;
    @(posedge clock);
    #1;
    bus.branch_taken = 1'b0;
    chk("valid_legal", 32'(bus.instr_valid == 2'b10), 32'd0);
    if (br) begin
      nbr++;
      chk("br_valid", 32'(bus.instr_valid), 32'd0);
      chk("br_pc", bus.PC_input, tgt & ~32'd3);
      exp_pc   = tgt & ~32'd3;
      next_req = {tgt[14:4], 4'd0};
    end else if (st) begin
      chk("hold_valid", 32'(bus.instr_valid), 32'(prev_v));
      chk("hold_pc", bus.PC_input, prev_pc);
      if (prev_v[0]) chk("hold_i0", bus.instr0, prev_i0);
      if (prev_v[1]) chk("hold_i1", bus.instr1, prev_i1);
    end else if (bus.instr_valid != 2'b00) begin
      chk("stream_pc", bus.PC_input, exp_pc);
      chk("stream_i0", bus.instr0, word_at(exp_pc));
      exp_pc += 4;
      issued++;
      if (bus.instr_valid[1]) begin
        chk("stream_i1", bus.instr1, word_at(exp_pc));
        exp_pc += 4;
        issued++;
      end
    end
    prev_v  = bus.instr_valid;
    prev_pc = bus.PC_input;
    prev_i0 = bus.instr0;
    prev_i1 = bus.instr1;

    was_pending     = pending;
    bus.ls_rd_valid = 1'b0;
    if (pending) begin
      cd--;
      if (cd <= 0) begin
        bus.ls_rd_valid = 1'b1;
        bus.ls_rd_data  = line_data(pend_addr);
        pending = 1'b0;
      end
    end
    if (bus.ls_rd_req) begin
      nreq++;
      chk("one_outstanding", 32'(was_pending), 32'd0);
      chk("req_addr", 32'(bus.ls_rd_addr), 32'(next_req));
      next_req  = next_req + 15'd16;
      pending   = 1'b1;
      pend_addr = bus.ls_rd_addr;
      cd        = $urandom_range(1, lat_max);
    end
  endtask

  task automatic apply_reset(input bit late_valid);
    #2;
    reset            = 1'b0;
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b0;
    bus.ls_rd_valid  = 1'b0;
    #1;
    chk("rst_req", 32'(bus.ls_rd_req), 32'd0);
    chk("rst_addr", 32'(bus.ls_rd_addr), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc", bus.PC_input, RESET_PC);
    chk("rst_i0", bus.instr0, 32'd0);
    chk("rst_i1", bus.instr1, 32'd0);
    pending  = 1'b0;
    cd       = 0;
    next_req = {RESET_PC[14:4], 4'd0};
    exp_pc   = RESET_PC;
    nreq     = 0;
    nbr      = 0;
    prev_v   = 2'b00;
    prev_pc  = RESET_PC;
    prev_i0  = '0;
    prev_i1  = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    if (late_valid) begin
      bus.ls_rd_valid = 1'b1;
      bus.ls_rd_data  = {4{32'hDEAD_BEEF}};
    end
  endtask

  task automatic wait_req(input string nm, output logic [14:0] a);
    int n;
    n = 0;
    a = '0;
    do begin
      tick();
      n++;
    end while (!bus.ls_rd_req && n < 60);
    if (!bus.ls_rd_req) chk({nm, "_timeout"}, 32'd1, 32'd0);
    else a = bus.ls_rd_addr;
  endtask

  task automatic wait_issue(input string nm, output logic [31:0] pc, output logic [31:0] i0);
    int n;
    n  = 0;
    pc = '0;
    i0 = '0;
    do begin
      tick();
      n++;
    end while (bus.instr_valid == 2'b00 && n < 60);
    if (bus.instr_valid == 2'b00) chk({nm, "_timeout"}, 32'd1, 32'd0);
    else begin
      pc = bus.PC_input;
      i0 = bus.instr0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] a;
    logic [31:0] pc, i0;
    int          n;

    // Reset release, 1-cycle local store, no stall: cycle-exact expectations
    tbl[0] = '{1'b0, 1'b1, 15'h000, 2'b00, 32'd0,  32'd0};
    tbl[1] = '{1'b0, 1'b0, 15'h000, 2'b00, 32'd0,  32'd0};
    tbl[2] = '{1'b0, 1'b0, 15'h000, 2'b00, 32'd0,  32'd0};
    tbl[3] = '{1'b0, 1'b1, 15'h010, 2'b11, 32'd0,  32'h1000_0000};
    tbl[4] = '{1'b0, 1'b0, 15'h000, 2'b11, 32'd8,  32'h1000_0002};
    tbl[5] = '{1'b0, 1'b0, 15'h000, 2'b00, 32'd0,  32'd0};
    tbl[6] = '{1'b0, 1'b1, 15'h020, 2'b11, 32'd16, 32'h1000_0004};
    tbl[7] = '{1'b0, 1'b0, 15'h000, 2'b11, 32'd24, 32'h1000_0006};
    tbl[8] = '{1'b0, 1'b0, 15'h000, 2'b00, 32'd0,  32'd0};

    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.stall         = 1'b0;
    bus.ls_rd_valid   = 1'b0;
    bus.ls_rd_data    = '0;
    lat_max = 1;
    issued  = 0;
    apply_reset(1'b0);

    for (int i = 0; i < 9; i++) begin
      bus.stall = tbl[i].stall;
      tick();
      chk($sformatf("vec%0d_req", i), 32'(bus.ls_rd_req), 32'(tbl[i].exp_req));
      if (tbl[i].exp_req) chk($sformatf("vec%0d_addr", i), 32'(bus.ls_rd_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid != 2'b00) begin
        chk($sformatf("vec%0d_pc", i), bus.PC_input, tbl[i].exp_pc);
        chk($sformatf("vec%0d_i0", i), bus.instr0, tbl[i].exp_i0);
      end
    end

    // Stall for 10 cycles right after the first issue
    apply_reset(1'b0);
    wait_issue("st_first", pc, i0);
    chk("st_first_pc", pc, 32'd0);
    bus.stall = 1'b1;
    repeat (10) tick();
    chk("stall_reqs", 32'(nreq), 32'd2);
    bus.stall = 1'b0;
    tick();
    chk("resume_valid", 32'(bus.instr_valid), 32'b11);
    chk("resume_pc", bus.PC_input, 32'd8);
    repeat (10) tick();

    // Redirect while a line is outstanding: returned line is dropped
    apply_reset(1'b0);
    wait_req("bw_req0", a);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0124;
    wait_req("bw_req1", a);
    chk("bw_addr", 32'(a), 32'h120);
    wait_issue("bw_iss0", pc, i0);
    chk("bw_pc0", pc, 32'h124);
    chk("bw_i0", i0, word_at(32'h124));
    wait_issue("bw_iss1", pc, i0);
    chk("bw_pc1", pc, 32'h12C);
    wait_issue("bw_iss2", pc, i0);
    chk("bw_pc2", pc, 32'h130);

    // Redirect on the same edge as returning data, under stall
    repeat (6) tick();
    n = 0;
    while (!bus.ls_rd_valid && n < 60) begin
      tick();
      n++;
    end
    if (!bus.ls_rd_valid) chk("bs_sync_timeout", 32'd1, 32'd0);
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0200;
    tick();
    wait_req("bs_req", a);
    chk("bs_addr", 32'(a), 32'h200);
    chk("bs_empty", 32'(bus.instr_valid), 32'd0);
    bus.stall = 1'b0;
    wait_issue("bs_iss", pc, i0);
    chk("bs_pc", pc, 32'h200);
    chk("bs_i0", i0, word_at(32'h200));

    // Local-store address wrap
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_7FF8;
    wait_req("wr_req0", a);
    chk("wr_addr0", 32'(a), 32'h7FF0);
    wait_issue("wr_iss0", pc, i0);
    chk("wr_pc0", pc, 32'h7FF8);
    chk("wr_req1", 32'(bus.ls_rd_req), 32'd1);
    chk("wr_addr1", 32'(bus.ls_rd_addr), 32'h0000);
    wait_issue("wr_iss1", pc, i0);
    chk("wr_pc1", pc, 32'h8000);
    chk("wr_i1", i0, 32'h1000_0000);

    // Reset while waiting for a line, then a stray late beat
    wait_req("rw_req0", a);
    apply_reset(1'b1);
    wait_req("rw_req1", a);
    chk("rw_addr", 32'(a), 32'h0000);
    chk("rw_first_req_cycle", 32'(nreq), 32'd1);
    wait_issue("rw_iss", pc, i0);
    chk("rw_pc", pc, RESET_PC);
    chk("rw_i0", i0, word_at(RESET_PC));

    // Randomized traffic against the stream model
    apply_reset(1'b0);
    lat_max = 3;
    issued  = 0;
    for (int c = 0; c < 2000; c++) begin
      bus.stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 3) begin
        bus.branch_taken  = 1'b1;
        bus.branch_target = $urandom;
      end
      tick();
    end
    chk("rnd_progress", 32'(issued >= 300), 32'd1);
`ifdef SPU_FETCH_PERF_CNT_EN
    chk("flush_cnt", 32'(flush_cnt), 32'(nbr));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
